// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types, select codes and match helper for hazard/forwarding
//
// Select codes for the EXE operand muxes, the per-stage destination record
// kept as shadow state, and the source-vs-stage match rule.
// Destination fields are REG_W_MAX wide; narrower register indices are
// zero-extended by the top, so REG_W must not exceed REG_W_MAX.
package hazard_pkg;

  localparam int REG_W_MAX = 8;

  localparam logic [1:0] SEL_REG = 2'd0;  // register-file value
  localparam logic [1:0] SEL_MEM = 2'd1;  // ALU_result_in (MEM-stage result)
  localparam logic [1:0] SEL_WB  = 2'd2;  // WB_result_in

  localparam logic [REG_W_MAX-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [REG_W_MAX-1:0] dest;
    logic                 wb_en;
    logic                 mem_r_en;
  } stage_dst_t;

  localparam stage_dst_t STAGE_BUBBLE = '{dest: REG_ZERO, wb_en: 1'b0, mem_r_en: 1'b0};

  // Register 0 is hard-wired, so it never matches a producer.
  function automatic logic stage_match(input logic [REG_W_MAX-1:0] src, input stage_dst_t st);
    return (src != REG_ZERO) && st.wb_en && (st.dest == src);
  endfunction

endpackage

// File: rtl/fwd_select.sv
// rtl/fwd_select.sv - combinational forwarding select for one EXE operand
//
// Ports:
//   src     in   source register index (zero-extended)
//   used    in   the operand actually reads src
//   exe_st  in   shadow destination record of the EXE stage
//   mem_st  in   shadow destination record of the MEM stage
//   sel     out  2-bit mux select (SEL_REG / SEL_MEM / SEL_WB)
module fwd_select
  import hazard_pkg::*;
(
  input  logic [REG_W_MAX-1:0] src,
  input  logic                 used,
  input  stage_dst_t           exe_st,
  input  stage_dst_t           mem_st,
  output logic [1:0]           sel
);

  // Load flags are irrelevant to select choice; the top handles load-use.
  logic unused_ld;
  assign unused_ld = exe_st.mem_r_en ^ mem_st.mem_r_en;

  // EXE is checked first: the newest producer's value wins.
  always_comb begin
    sel = SEL_REG;
    if (used && stage_match(src, exe_st)) begin
      sel = SEL_MEM;
    end else if (used && stage_match(src, mem_st)) begin
      sel = SEL_WB;
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// rtl/hazard_forward_unit.sv - hazard detection and EXE forwarding-select producer
//
// Optional feature macro: FORWARDING_EN. Without it, all selects are held
// at SEL_REG and any used source that matches EXE or MEM stalls.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   id_src1/id_src2/id_dest  register indices of the ID instruction
//   id_wb_en, id_mem_r_en    ID instruction writes id_dest / is a load
//   id_src1_used             val1 reads id_src1
//   id_val2_is_reg           val2 is id_src2 (low: immediate)
//   id_src2_used             id_src2 is read at all
//   br_taken                 EXE branch taken, flush ID instruction
//   val1_sel/val2_sel/src2_sel  registered EXE mux selects
//   hazard_stall             combinational stall request to IF/ID
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_wb_en,
  input  logic             id_mem_r_en,
  input  logic             id_src1_used,
  input  logic             id_val2_is_reg,
  input  logic             id_src2_used,
  input  logic             br_taken,
  output logic [1:0]       val1_sel,
  output logic [1:0]       val2_sel,
  output logic [1:0]       src2_sel,
  output logic             hazard_stall
);

  logic [REG_W_MAX-1:0] src1_x;
  logic [REG_W_MAX-1:0] src2_x;
  stage_dst_t           id_st;
  stage_dst_t           exe_q;
  stage_dst_t           mem_q;
  logic                 raw;
  logic                 bubble;
  logic [1:0]           val1_nxt;
  logic [1:0]           val2_nxt;
  logic [1:0]           src2_nxt;

  assign src1_x = REG_W_MAX'(id_src1);
  assign src2_x = REG_W_MAX'(id_src2);
  assign id_st  = '{dest: REG_W_MAX'(id_dest), wb_en: id_wb_en, mem_r_en: id_mem_r_en};

`ifdef FORWARDING_EN
  fwd_select u_val1 (
    .src    (src1_x),
    .used   (id_src1_used),
    .exe_st (exe_q),
    .mem_st (mem_q),
    .sel    (val1_nxt)
  );

  // An immediate val2 never forwards.
  fwd_select u_val2 (
    .src    (src2_x),
    .used   (id_src2_used & id_val2_is_reg),
    .exe_st (exe_q),
    .mem_st (mem_q),
    .sel    (val2_nxt)
  );

  // src2 carries store data / branch compare, so it forwards even when val2 is an immediate.
  fwd_select u_src2 (
    .src    (src2_x),
    .used   (id_src2_used),
    .exe_st (exe_q),
    .mem_st (mem_q),
    .sel    (src2_nxt)
  );

  // Only a load in EXE is unresolvable: its data exists one stage later.
  assign raw = ((id_src1_used & stage_match(src1_x, exe_q)) |
                (id_src2_used & stage_match(src2_x, exe_q))) & exe_q.mem_r_en;
`else
  assign val1_nxt = SEL_REG;
  assign val2_nxt = SEL_REG;
  assign src2_nxt = SEL_REG;

  // No bypass paths: wait until the producer has left MEM.
  assign raw = (id_src1_used & (stage_match(src1_x, exe_q) | stage_match(src1_x, mem_q))) |
               (id_src2_used & (stage_match(src2_x, exe_q) | stage_match(src2_x, mem_q)));

  logic unused_cfg;
  assign unused_cfg = id_val2_is_reg ^ exe_q.mem_r_en ^ mem_q.mem_r_en;
`endif

  // A flush squashes the ID instruction, so it also cancels its stall.
  assign hazard_stall = raw & ~br_taken;
  assign bubble       = hazard_stall | br_taken;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exe_q    <= STAGE_BUBBLE;
      mem_q    <= STAGE_BUBBLE;
      val1_sel <= SEL_REG;
      val2_sel <= SEL_REG;
      src2_sel <= SEL_REG;
    end else begin
      exe_q    <= bubble ? STAGE_BUBBLE : id_st;
      mem_q    <= exe_q;
      val1_sel <= bubble ? SEL_REG : val1_nxt;
      val2_sel <= bubble ? SEL_REG : val2_nxt;
      src2_sel <= bubble ? SEL_REG : src2_nxt;
    end
  end

endmodule
